// File: rtl/or1k_spr_initiator_pkg.sv
// Shared SPR initiator types: FSM state encoding, well-known responder addresses
// and helpers to split an SPR address into group and offset.
package or1k_spr_initiator_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StResp   = 2'd2
   } spr_state_e;

   localparam logic [15:0] SPR_ADDR_PICMR = 16'h4800;
   localparam logic [15:0] SPR_ADDR_PICSR = 16'h4802;

   function automatic logic [4:0] spr_group(input logic [15:0] addr);
      return addr[15:11];
   endfunction

   function automatic logic [10:0] spr_offset(input logic [15:0] addr);
      return addr[10:0];
   endfunction

endpackage

// File: rtl/or1k_spr_timeout.sv
// Access timeout counter: cleared by load_i, advanced by count_i; expired_o flags
// the last permitted access cycle that still lacks an ack.
module or1k_spr_timeout #(
   parameter int unsigned Timeout = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic count_i,
   output logic expired_o
);

   localparam int unsigned CntW = $clog2(Timeout + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (count_i) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = count_i && (cnt_q == CntW'(Timeout - 1));

endmodule

// File: rtl/or1k_spr_initiator.sv
// SPR bus initiator: one pipeline mtspr/mfspr at a time, held on the bus until ack.
// Define OR1K_SPR_TIMEOUT_EN to abort with rsp_err_o when no responder acks.
module or1k_spr_initiator
   import or1k_spr_initiator_pkg::*;
#(
   parameter int unsigned OPTION_SPR_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   input  logic        req_we_i,
   input  logic [15:0] req_addr_i,
   input  logic [31:0] req_dat_i,
   output logic        req_ready_o,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_dat_o,
   output logic        rsp_err_o,
   input  logic        flush_i,
   output logic        spr_access_o,
   output logic        spr_we_o,
   output logic [15:0] spr_addr_o,
   output logic [31:0] spr_dat_o,
   input  logic        spr_bus_ack_i,
   input  logic [31:0] spr_dat_i
);

   if (OPTION_SPR_TIMEOUT < 1) begin : g_bad_timeout
      $error("OPTION_SPR_TIMEOUT must be at least 1");
   end

   spr_state_e  state_q, state_d;
   logic        we_q, we_d;
   logic [15:0] addr_q, addr_d;
   logic [31:0] wdat_q, wdat_d;
   logic [31:0] rdat_q, rdat_d;
   logic        err_q, err_d;
   logic        tmo_expired;

`ifdef OR1K_SPR_TIMEOUT_EN
   // Held clear while idle so it always starts from zero on entering ACCESS.
   or1k_spr_timeout #(
      .Timeout (OPTION_SPR_TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .load_i    (state_q == StIdle),
      .count_i   ((state_q == StAccess) && !spr_bus_ack_i),
      .expired_o (tmo_expired)
   );
`else
   assign tmo_expired = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdat_d  = wdat_q;
      rdat_d  = rdat_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               we_d    = req_we_i;
               addr_d  = req_addr_i;
               wdat_d  = req_dat_i;
               state_d = StAccess;
            end
         end
         StAccess: begin
            if (spr_bus_ack_i && !flush_i) begin
               rdat_d  = we_q ? 32'h0 : spr_dat_i;
               err_d   = 1'b0;
               state_d = StResp;
            end else if (flush_i || spr_bus_ack_i) begin
               // Flushed: a coincident ack still completed the access, but nobody wants the result.
               state_d = StIdle;
            end else if (tmo_expired) begin
               rdat_d  = 32'h0;
               err_d   = 1'b1;
               state_d = StResp;
            end
         end
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         addr_q  <= 16'h0;
         wdat_q  <= 32'h0;
         rdat_q  <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
         err_q   <= err_d;
      end
   end

   assign req_ready_o  = (state_q == StIdle);
   assign rsp_valid_o  = (state_q == StResp);
   assign spr_access_o = (state_q == StAccess);
   assign spr_we_o     = spr_access_o && we_q;
   assign spr_addr_o   = spr_access_o ? addr_q : 16'h0;
   assign spr_dat_o    = spr_access_o ? wdat_q : 32'h0;
   assign rsp_dat_o    = rdat_q;
   assign rsp_err_o    = err_q;

endmodule

// File: tb/tb_or1k_spr_initiator.sv
// Self-checking bench for or1k_spr_initiator: directed table, hand-written corner
// sequences and randomized accesses checked against a transaction-level model.
module tb_or1k_spr_initiator;

   localparam int Inf = 1000000;
`ifdef OR1K_SPR_TIMEOUT_EN
   localparam int Tmo = 15;
`else
   localparam int Tmo = Inf;
`endif

   logic        clk, rst;
   logic        req_valid_i, req_we_i, req_ready_o;
   logic [15:0] req_addr_i;
   logic [31:0] req_dat_i;
   logic        rsp_valid_o, rsp_err_o;
   logic [31:0] rsp_dat_o;
   logic        flush_i;
   logic        spr_access_o, spr_we_o;
   logic [15:0] spr_addr_o;
   logic [31:0] spr_dat_o;
   logic        spr_bus_ack_i;
   logic [31:0] spr_dat_i;

   int          n_vec  = 0;
   int          n_fail = 0;
   logic [31:0] last_dat = 32'h0;
   logic        last_err = 1'b0;

   or1k_spr_initiator #(
      .OPTION_SPR_TIMEOUT (15)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid_i   (req_valid_i),
      .req_we_i      (req_we_i),
      .req_addr_i    (req_addr_i),
      .req_dat_i     (req_dat_i),
      .req_ready_o   (req_ready_o),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_dat_o     (rsp_dat_o),
      .rsp_err_o     (rsp_err_o),
      .flush_i       (flush_i),
      .spr_access_o  (spr_access_o),
      .spr_we_o      (spr_we_o),
      .spr_addr_o    (spr_addr_o),
      .spr_dat_o     (spr_dat_o),
      .spr_bus_ack_i (spr_bus_ack_i),
      .spr_dat_i     (spr_dat_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [31:0] wdat;
      logic [31:0] rdat;
      int          ack_cyc;
      int          flush_cyc;
      int          acc;
      logic        rsp;
      logic        err;
      logic [31:0] dat;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Transaction outcome from the rules: whichever of ack, flush or timeout comes first ends
   // the access; a flush on or before that cycle suppresses the response.
   function automatic void model(input int ack_cyc, input int flush_cyc, output int acc,
                                 output logic rsp, output logic err);
      int a, f, e;
      a = (ack_cyc == 0) ? Inf : ack_cyc;
      f = (flush_cyc == 0) ? Inf : flush_cyc;
      e = a;
      if (f < e) e = f;
      if (Tmo < e) e = Tmo;
      acc = e;
      rsp = (f > e);
      err = rsp && (a > e);
   endfunction

   // Entered just after a posedge with the DUT idle; leaves just after a posedge, idle again.
   task automatic run_txn(input logic we, input logic [15:0] addr, input logic [31:0] wdat,
                          input logic [31:0] rdat, input int ack_cyc, input int flush_cyc,
                          input int exp_acc, input logic exp_rsp, input logic exp_err,
                          input logic [31:0] exp_dat);
      req_valid_i = 1'b1;
      req_we_i    = we;
      req_addr_i  = addr;
      req_dat_i   = wdat;
      @(negedge clk);
      check("c0_ready", 32'(req_ready_o), 32'd1);
      check("c0_access", 32'(spr_access_o), 32'd0);
      check("c0_rsp_valid", 32'(rsp_valid_o), 32'd0);
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      req_we_i    = ($urandom_range(0, 1) == 1);
      req_addr_i  = 16'($urandom);
      req_dat_i   = $urandom;
      for (int k = 1; k <= exp_acc + 1; k++) begin
         spr_bus_ack_i = (k == ack_cyc);
         flush_i       = (k == flush_cyc);
         spr_dat_i     = (k == ack_cyc) ? rdat : $urandom;
         @(negedge clk);
         if (k <= exp_acc) begin
            check("acc_access", 32'(spr_access_o), 32'd1);
            check("acc_we", 32'(spr_we_o), 32'(we));
            check("acc_addr", 32'(spr_addr_o), 32'(addr));
            check("acc_dat", spr_dat_o, wdat);
            check("acc_ready", 32'(req_ready_o), 32'd0);
            check("acc_rsp_valid", 32'(rsp_valid_o), 32'd0);
         end else begin
            check("end_access", 32'(spr_access_o), 32'd0);
            check("end_we", 32'(spr_we_o), 32'd0);
            check("end_addr", 32'(spr_addr_o), 32'd0);
            check("end_dat", spr_dat_o, 32'd0);
            check("end_rsp_valid", 32'(rsp_valid_o), 32'(exp_rsp));
            check("end_ready", 32'(req_ready_o), 32'(!exp_rsp));
            check("end_rsp_dat", rsp_dat_o, exp_rsp ? exp_dat : last_dat);
            check("end_rsp_err", 32'(rsp_err_o), 32'(exp_rsp ? exp_err : last_err));
         end
         @(posedge clk);
         #1;
      end
      spr_bus_ack_i = 1'b0;
      flush_i       = 1'b0;
      if (exp_rsp) begin
         last_dat = exp_dat;
         last_err = exp_err;
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = 16'h0; req_dat_i = 32'h0;
      flush_i = 1'b0; spr_bus_ack_i = 1'b0; spr_dat_i = 32'h0;

      tbl[0] = '{1'b1, 16'h4800, 32'h000000A5, 32'h5A5A5A5A, 1, 0, 1, 1'b1, 1'b0, 32'h0};
      tbl[1] = '{1'b0, 16'h4802, 32'h11111111, 32'h00000003, 1, 0, 1, 1'b1, 1'b0, 32'h3};
      tbl[2] = '{1'b0, 16'h4802, 32'h22222222, 32'hDEADBEEF, 3, 0, 3, 1'b1, 1'b0, 32'hDEADBEEF};
      tbl[3] = '{1'b1, 16'h4800, 32'h0000F00D, 32'h0, 3, 2, 2, 1'b0, 1'b0, 32'h0};
      tbl[4] = '{1'b0, 16'h2801, 32'h0, 32'hCAFEF00D, 2, 2, 2, 1'b0, 1'b0, 32'h0};
      tbl[5] = '{1'b0, 16'h4802, 32'h0, 32'h12345678, 1, 0, 1, 1'b1, 1'b0, 32'h12345678};
      tbl[6] = '{1'b1, 16'hFFFF, 32'hFFFFFFFF, 32'h87654321, 4, 0, 4, 1'b1, 1'b0, 32'h0};
      tbl[7] = '{1'b0, 16'h4802, 32'h0, 32'hA5A5A5A5, 1, 2, 1, 1'b1, 1'b0, 32'hA5A5A5A5};

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(req_ready_o), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("rst_rsp_dat", rsp_dat_o, 32'd0);
      check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
      check("rst_access", 32'(spr_access_o), 32'd0);
      check("rst_we", 32'(spr_we_o), 32'd0);
      check("rst_addr", 32'(spr_addr_o), 32'd0);
      check("rst_dat", spr_dat_o, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) begin
         run_txn(tbl[i].we, tbl[i].addr, tbl[i].wdat, tbl[i].rdat, tbl[i].ack_cyc,
                 tbl[i].flush_cyc, tbl[i].acc, tbl[i].rsp, tbl[i].err, tbl[i].dat);
      end

      // Absent responder.
`ifdef OR1K_SPR_TIMEOUT_EN
      run_txn(1'b0, 16'h4802, 32'h0, 32'h0, 0, 0, 15, 1'b1, 1'b1, 32'h0);
      run_txn(1'b0, 16'h4802, 32'h0, 32'h55AA55AA, 0, 15, 15, 1'b0, 1'b0, 32'h0);
`else
      run_txn(1'b0, 16'h4802, 32'h0, 32'h0, 0, 105, 105, 1'b0, 1'b0, 32'h0);
`endif
      run_txn(1'b1, 16'h4800, 32'h00000077, 32'h0, 2, 0, 2, 1'b1, 1'b0, 32'h0);

      // Reset in the middle of an access.
      req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 16'h4800; req_dat_i = 32'h99;
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("pre_rst_access", 32'(spr_access_o), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_access", 32'(spr_access_o), 32'd0);
      check("mid_rst_we", 32'(spr_we_o), 32'd0);
      check("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("mid_rst_ready", 32'(req_ready_o), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      last_dat = 32'h0;
      last_err = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("post_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
         check("post_rst_access", 32'(spr_access_o), 32'd0);
      end
      @(posedge clk);
      #1;

      for (int i = 0; i < 150; i++) begin
         logic        we;
         logic [31:0] rdat, dat;
         int          ack_cyc, flush_cyc, acc;
         logic        rsp, err;
         we        = ($urandom_range(0, 1) == 1);
         rdat      = $urandom;
         ack_cyc   = $urandom_range(1, 20);
         flush_cyc = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 22) : 0;
         model(ack_cyc, flush_cyc, acc, rsp, err);
         dat = (we || err) ? 32'h0 : rdat;
         run_txn(we, 16'($urandom), $urandom, rdat, ack_cyc, flush_cyc, acc, rsp, err, dat);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
